// File: rtl/exe_mem_pkg.sv
// Shared EXE/MEM pipeline definitions: default widths, skid-buffer state encoding
// and the payload field layout used by the EXE, EXE/MEM register and MEM stages.
package exe_mem_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEST_W_DEF = 4;
  localparam int unsigned STALL_W    = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // Payload layout, MSB first; the register mirrors this ordering at any width.
  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [DEST_W_DEF-1:0] dest;
    logic [DATA_W_DEF-1:0] alu_result;
    logic [DATA_W_DEF-1:0] st_val;
  } exe_mem_payload_t;

endpackage

// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register built as a two-entry skid buffer so in_ready is a
// pure flop, plus a saturating back-pressure cycle counter.
module exe_mem_reg
  import exe_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEST_W = DEST_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_alu_result,
  input  logic [DATA_W-1:0]  in_st_val,
  input  logic [DEST_W-1:0]  in_dest,
  input  logic               in_wb_en,
  input  logic               in_mem_r_en,
  input  logic               in_mem_w_en,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_alu_result,
  output logic [DATA_W-1:0]  out_st_val,
  output logic [DEST_W-1:0]  out_dest,
  output logic               out_wb_en,
  output logic               out_mem_r_en,
  output logic               out_mem_w_en,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int unsigned CTRL_W = 3;

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] st_val;
  } payload_t;

  state_e             state_q, state_d;
  payload_t           head_q, head_d;
  payload_t           skid_q, skid_d;
  payload_t           in_pl;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               accept, retire;

  assign in_pl = {in_wb_en, in_mem_r_en, in_mem_w_en, in_dest, in_alu_result, in_st_val};

  // Next-state, entry movement and registered output values.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    stall_d = stall_q;
    accept  = in_valid & in_ready_q;
    retire  = out_valid_q & out_ready;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_d  = in_pl;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && retire) begin
          head_d = in_pl;
        end else if (accept) begin
          skid_d  = in_pl;
          state_d = ST_FULL;
        end else if (retire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (retire) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush drops both entries; head data is left in place so outputs hold.
    if (flush) begin
      state_d = ST_EMPTY;
      head_d  = head_q;
      skid_d  = skid_q;
    end

    if (out_valid_q && !out_ready && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + STALL_W'(1);
    end

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
    ctrl_d      = {head_d.wb_en, head_d.mem_r_en, head_d.mem_w_en} & {CTRL_W{out_valid_d}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      stall_q     <= stall_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_alu_result = head_q.alu_result;
  assign out_st_val     = head_q.st_val;
  assign out_dest       = head_q.dest;
  assign out_wb_en      = ctrl_q[2];
  assign out_mem_r_en   = ctrl_q[1];
  assign out_mem_w_en   = ctrl_q[0];
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_exe_mem_reg.sv
// Scoreboard bench for exe_mem_reg: accepted items queue up in a FIFO model,
// a negedge monitor pops them as the DUT retires and compares every output.
module tb_exe_mem_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned PW = 3 + RW + 2 * DW;

  typedef logic [PW-1:0] pl_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_alu_result, in_st_val;
  logic [RW-1:0] in_dest;
  logic          in_wb_en, in_mem_r_en, in_mem_w_en;
  logic          flush;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_alu_result, out_st_val;
  logic [RW-1:0] out_dest;
  logic          out_wb_en, out_mem_r_en, out_mem_w_en;
  logic [15:0]   stall_cnt;

  int checks = 0;
  int errors = 0;

  exe_mem_reg #(.DATA_W(DW), .DEST_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_st_val(in_st_val), .in_dest(in_dest),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_st_val(out_st_val), .out_dest(out_dest),
    .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is just a FIFO of at most two items.
  pl_t         sb[$];
  logic        m_ready, m_valid;
  logic [15:0] m_stall;
  pl_t         m_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      m_ready = 1'b0;
      m_valid = 1'b0;
      m_stall = 16'd0;
      m_last  = '0;
    end else begin
      if (m_valid && !out_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (flush) sb.delete();
      else if (in_valid && m_ready)
        sb.push_back({in_wb_en, in_mem_r_en, in_mem_w_en, in_dest, in_alu_result, in_st_val});
      m_ready = (sb.size() < 2);
      m_valid = (sb.size() > 0);
      if (m_valid) m_last = sb[0];
    end
  end

  // Monitor: checks the presented state, pops when the DUT hands an item to MEM.
  always @(negedge clk) begin
    pl_t  got;
    pl_t  exp;
    got = {out_wb_en, out_mem_r_en, out_mem_w_en, out_dest, out_alu_result, out_st_val};
    chk("out_valid", PW'(out_valid), PW'(m_valid));
    chk("in_ready", PW'(in_ready), PW'(m_ready));
    chk("stall_cnt", PW'(stall_cnt), PW'(m_stall));
    if (!out_valid) begin
      chk("ctrl_gated", PW'({out_wb_en, out_mem_r_en, out_mem_w_en}), PW'(0));
      exp = m_last;
      exp[PW-1 -: 3] = 3'b000;
      chk("data_hold", {3'b000, got[PW-4:0]}, exp);
    end else if (out_ready) begin
      if (sb.size() == 0) begin
        chk("retire_unexpected", got, '1);
      end else begin
        exp = sb.pop_front();
        chk("retire_payload", got, exp);
      end
    end else if (sb.size() > 0) begin
      chk("head_payload", got, sb[0]);
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] alu, input logic [RW-1:0] d,
                       input logic [2:0] ctl, input logic ordy, input logic fl);
    @(posedge clk);
    #2;
    in_valid      = v;
    in_alu_result = alu;
    in_st_val     = ~alu ^ DW'($urandom);
    in_dest       = d;
    {in_wb_en, in_mem_r_en, in_mem_w_en} = ctl;
    out_ready     = ordy;
    flush         = fl;
  endtask

  task automatic idle(input logic ordy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 3'b000, ordy, 1'b0);
  endtask

  task automatic async_reset_check(input string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk({tag, "_valid"}, PW'(out_valid), PW'(0));
    chk({tag, "_ready"}, PW'(in_ready), PW'(0));
    chk({tag, "_stall"}, PW'(stall_cnt), PW'(0));
    chk({tag, "_data"}, PW'({out_alu_result, out_dest, out_wb_en}), PW'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_alu_result = '0; in_st_val = '0; in_dest = '0;
    in_wb_en = 1'b0; in_mem_r_en = 1'b0; in_mem_w_en = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("por_valid", PW'(out_valid), PW'(0));
    chk("por_ready", PW'(in_ready), PW'(0));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single pass.
    drive(1'b1, 32'h5, 4'd3, 3'b100, 1'b1, 1'b0);
    idle(1'b1, 3);

    // Back-pressure fill, an ignored offer while full, then drain.
    drive(1'b1, 32'h11, 4'd1, 3'b010, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 4'd2, 3'b001, 1'b0, 1'b0);
    idle(1'b0, 2);
    drive(1'b1, 32'h99, 4'd9, 3'b111, 1'b0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 3);

    // Streaming.
    for (int i = 1; i <= 10; i++) drive(1'b1, DW'(i), RW'(i), 3'b100, 1'b1, 1'b0);
    idle(1'b1, 2);

    // Flush while full with a write offered.
    drive(1'b1, 32'h44, 4'd4, 3'b001, 1'b0, 1'b0);
    drive(1'b1, 32'h55, 4'd5, 3'b001, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 4'd6, 3'b001, 1'b0, 1'b1);
    idle(1'b1, 3);

    // Flush from ONE with same-cycle accept and retire.
    drive(1'b1, 32'h66, 4'd7, 3'b110, 1'b1, 1'b0);
    drive(1'b1, 32'h67, 4'd8, 3'b110, 1'b1, 1'b1);
    idle(1'b1, 2);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      drive(1'($urandom_range(0, 3) != 0), DW'($urandom), RW'($urandom_range(0, 15)),
            3'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    idle(1'b1, 3);

    // Async reset while full, then new data only.
    drive(1'b1, 32'hA1, 4'd1, 3'b111, 1'b0, 1'b0);
    drive(1'b1, 32'hA2, 4'd2, 3'b111, 1'b0, 1'b0);
    idle(1'b0, 1);
    async_reset_check("rst_mid");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(1'b1, 1);
    drive(1'b1, 32'h77, 4'd7, 3'b100, 1'b1, 1'b0);
    idle(1'b1, 3);

    // Saturation.
    drive(1'b1, 32'hBEEF, 4'd2, 3'b100, 1'b0, 1'b0);
    idle(1'b0, 70000);
    @(negedge clk);
    chk("stall_sat", PW'(stall_cnt), PW'(16'hFFFF));
    idle(1'b0, 5);
    @(negedge clk);
    chk("stall_sat_hold", PW'(stall_cnt), PW'(16'hFFFF));
    idle(1'b1, 3);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
